// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard controller (host transmit side).
package kbd_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE, S_ERR
  } tx_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NORESP  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_NACK    = 2'b11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam int CNT_W = 20;

  // Frame as shifted out LSB first: data, odd parity, stop.
  function automatic logic [9:0] tx_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-FF synchronizer, consecutive-sample glitch filter, registered fall pulse.
module ps2_line_sync #(
  parameter int P_FILT_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);
  localparam int FW = $clog2(P_FILT_LEN + 1);

  logic [1:0]    sync_q;
  logic [FW-1:0] cnt_q;
  logic          level_q;
  logic          fall_q;

  // A new level is accepted only after P_FILT_LEN samples in a row disagree with the current one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      fall_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == FW'(P_FILT_LEN - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
        fall_q  <= level_q;
      end else begin
        cnt_q <= cnt_q + FW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte, check ACK.
module ps2_host_tx
  import kbd_pkg::*;
#(
  parameter int P_INHIBIT_CYC  = 5000,
  parameter int P_RESP_TO_CYC  = 750000,
  parameter int P_FRAME_TO_CYC = 100000,
  parameter int P_FILT_LEN     = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_en_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic [1:0] tx_err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_dat_oe_o
);
  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(P_INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_LIM  = CNT_W'(P_RESP_TO_CYC);
  localparam logic [CNT_W-1:0] FRAME_LIM = CNT_W'(P_FRAME_TO_CYC);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [9:0]       sh_q, sh_d;
  logic [3:0]       nfall_q, nfall_d;
  logic [1:0]       err_q, err_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done;
  logic             clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

  ps2_line_sync #(.P_FILT_LEN(P_FILT_LEN)) u_clk_sync (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(ps2_clk_i), .level_o(clk_lvl), .fall_o(clk_fall)
  );
  ps2_line_sync #(.P_FILT_LEN(P_FILT_LEN)) u_dat_sync (
    .clk_i(clk_i), .rst_i(rst_i), .line_i(ps2_dat_i), .level_o(dat_lvl), .fall_o(dat_fall_unused)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      sh_q     <= '0;
      nfall_q  <= '0;
      err_q    <= ERR_OK;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      nfall_q  <= nfall_d;
      err_q    <= err_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  // DATA->ACK keeps counting so the frame timeout spans first fall through the ACK edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_d != state_q && !(state_q == S_DATA && state_d == S_ACK)) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    nfall_d  = nfall_q;
    err_d    = err_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_en_i) begin
          sh_d     = tx_frame(tx_data_i);
          err_d    = ERR_OK;
          nfall_d  = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (cnt_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b1;
        if (clk_fall) begin
          dat_oe_d = ~sh_q[0];
          sh_d     = {1'b0, sh_q[9:1]};
          nfall_d  = 4'd1;
          state_d  = S_DATA;
        end else if (cnt_q > RESP_LIM) begin
          err_d    = ERR_NORESP;
          dat_oe_d = 1'b0;
          state_d  = S_ERR;
        end
      end
      S_DATA: begin
        if (cnt_q > FRAME_LIM) begin
          err_d    = ERR_TIMEOUT;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = S_ERR;
        end else if (clk_fall) begin
          // Fall 10 shifts out the stop bit (1), which releases the data line.
          dat_oe_d = ~sh_q[0];
          sh_d     = {1'b0, sh_q[9:1]};
          nfall_d  = nfall_q + 4'd1;
          if (nfall_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (cnt_q > FRAME_LIM) begin
          err_d    = ERR_TIMEOUT;
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          state_d  = S_ERR;
        end else if (clk_fall) begin
          err_d   = dat_lvl ? ERR_NACK : ERR_OK;
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_busy_o    = (state_q != S_IDLE);
  assign tx_done_o    = done;
  assign tx_err_o     = err_q;
  assign ps2_clk_oe_o = clk_oe_q;
  assign ps2_dat_oe_o = dat_oe_q;
endmodule
